dht11_receiver: RTL and testbench

Decodes the DHT11 single-wire response frame into humidity and temperature bytes. It sits directly downstream of the start-signal stage: that stage drives the host start pulse, releases the line, then pulses `start`. This block then times the sensor's response and 40 data bits on the 1 MHz divided clock, verifies the checksum, and presents registered readings with a one-cycle `valid` strobe.

---
 rtl/dht11_pkg.sv | 40 ++++
 rtl/dht11_edge_sync.sv | 38 +++
 rtl/dht11_receiver.sv | 156 +++++++++++++++
 tb/tb_dht11_receiver.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/dht11_pkg.sv
// Shared DHT11 definitions: FSM encoding, frame layout and default timing in microseconds.
// Timing defaults are also used by the start-signal stage.
package dht11_pkg;

  localparam int FRAME_BITS = 40;

  // Byte positions within the 40-bit frame, counted from the LSB byte
  localparam int BYTE_HUM_INT  = 4;
  localparam int BYTE_HUM_DEC  = 3;
  localparam int BYTE_TEMP_INT = 2;
  localparam int BYTE_TEMP_DEC = 1;
  localparam int BYTE_CSUM     = 0;

  localparam int DEF_CLK_PER_US     = 1;
  localparam int DEF_BIT1_THRESH_US = 40;
  localparam int DEF_TIMEOUT_US     = 200;

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_WAIT_RESP = 3'd1;
  localparam logic [2:0] ST_RESP_LOW  = 3'd2;
  localparam logic [2:0] ST_RESP_HIGH = 3'd3;
  localparam logic [2:0] ST_BIT_LOW   = 3'd4;
  localparam logic [2:0] ST_BIT_HIGH  = 3'd5;
  localparam logic [2:0] ST_CHECK     = 3'd6;

  typedef enum logic [2:0] {
    S_IDLE      = ST_IDLE,
    S_WAIT_RESP = ST_WAIT_RESP,
    S_RESP_LOW  = ST_RESP_LOW,
    S_RESP_HIGH = ST_RESP_HIGH,
    S_BIT_LOW   = ST_BIT_LOW,
    S_BIT_HIGH  = ST_BIT_HIGH,
    S_CHECK     = ST_CHECK
  } state_t;

  function automatic logic [7:0] frame_sum(input logic [39:0] f);
    return f[39:32] + f[31:24] + f[23:16] + f[15:8];
  endfunction

endpackage

// File: rtl/dht11_edge_sync.sv
// 2-FF synchronizer plus registered rise/fall pulses; pulses appear 3 cycles after the pin edge.
// Line idles high (pull-up), so reset preloads ones to avoid a spurious edge.
module dht11_edge_sync (
  input  logic clk,
  input  logic rst,
  input  logic i_din,
  output logic o_level,
  output logic o_rise,
  output logic o_fall
);

  logic r_meta;
  logic r_sync;
  logic r_prev;
  logic r_rise;
  logic r_fall;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_meta <= 1'b1;
      r_sync <= 1'b1;
      r_prev <= 1'b1;
      r_rise <= 1'b0;
      r_fall <= 1'b0;
    end else begin
      r_meta <= i_din;
      r_sync <= r_meta;
      r_prev <= r_sync;
      r_rise <= r_sync & ~r_prev;
      r_fall <= ~r_sync & r_prev;
    end
  end

  assign o_level = r_sync;
  assign o_rise  = r_rise;
  assign o_fall  = r_fall;

endmodule

// File: rtl/dht11_receiver.sv
// DHT11 response/bit decoder: times line phases, shifts 40 bits, strobes valid/checksum_err/timeout
// the cycle after CHECK; no backpressure. Checksum test enabled by `DHT11_CHECKSUM_EN.
module dht11_receiver
  import dht11_pkg::*;
#(
  parameter int CLK_PER_US     = DEF_CLK_PER_US,
  parameter int BIT1_THRESH_US = DEF_BIT1_THRESH_US,
  parameter int TIMEOUT_US     = DEF_TIMEOUT_US
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       dht11_data,
  output logic [7:0] hum_int,
  output logic [7:0] hum_dec,
  output logic [7:0] temp_int,
  output logic [7:0] temp_dec,
  output logic       valid,
  output logic       checksum_err,
  output logic       timeout,
  output logic       busy
);

  localparam int LIMIT  = TIMEOUT_US * CLK_PER_US;
  localparam int THRESH = BIT1_THRESH_US * CLK_PER_US;
  localparam int CNT_W  = $clog2(LIMIT + 1);

  state_t            r_state;
  state_t            w_next;
  logic [CNT_W-1:0]  r_cnt;
  logic [CNT_W:0]    w_len;
  logic [5:0]        r_bitcnt;
  logic [39:0]       r_shift;
  logic [7:0]        r_hum_int;
  logic [7:0]        r_hum_dec;
  logic [7:0]        r_temp_int;
  logic [7:0]        r_temp_dec;
  logic              r_valid;
  logic              r_timeout;
  logic              w_level;
  logic              w_unused_level;
  logic              w_rise;
  logic              w_fall;
  logic              w_edge;
  logic              w_sat;
  logic              w_bit;
  logic              w_timeout;
  logic              w_csum_ok;

  dht11_edge_sync u_sync (
    .clk     (clk),
    .rst     (rst),
    .i_din   (dht11_data),
    .o_level (w_level),
    .o_rise  (w_rise),
    .o_fall  (w_fall)
  );

  assign w_unused_level = w_level;
  assign w_edge = w_rise | w_fall;
  assign w_sat  = (r_cnt == CNT_W'(LIMIT));
  // r_cnt excludes the edge cycle itself, so add it back to get the true high time
  assign w_len  = {1'b0, r_cnt} + (CNT_W+1)'(1);
  assign w_bit  = (w_len >= (CNT_W+1)'(THRESH));

`ifdef DHT11_CHECKSUM_EN
  assign w_csum_ok = (frame_sum(r_shift) == r_shift[BYTE_CSUM*8 +: 8]);
`else
  assign w_csum_ok = 1'b1;
`endif

  always_comb begin
    w_next    = r_state;
    w_timeout = 1'b0;
    case (r_state)
      S_IDLE:      if (start)  w_next = S_WAIT_RESP;
      S_WAIT_RESP: if (w_fall) w_next = S_RESP_LOW;
      S_RESP_LOW:  if (w_rise) w_next = S_RESP_HIGH;
      S_RESP_HIGH: if (w_fall) w_next = S_BIT_LOW;
      S_BIT_LOW:   if (w_rise) w_next = S_BIT_HIGH;
      S_BIT_HIGH:
        if (w_fall) w_next = (r_bitcnt == 6'(FRAME_BITS - 1)) ? S_CHECK : S_BIT_LOW;
      S_CHECK:     w_next = S_IDLE;
      default:     w_next = S_IDLE;
    endcase
    if (r_state != S_IDLE && w_sat && !w_edge) begin
      w_next    = S_IDLE;
      w_timeout = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == S_IDLE || w_edge || w_next != r_state) r_cnt <= '0;
      else if (!w_sat) r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_bitcnt <= '0;
      r_shift  <= '0;
    end else if (r_state == S_IDLE && start) begin
      r_bitcnt <= '0;
      r_shift  <= '0;
    end else if (r_state == S_BIT_HIGH && w_fall) begin
      r_bitcnt <= r_bitcnt + 6'd1;
      r_shift  <= {r_shift[38:0], w_bit};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hum_int  <= '0;
      r_hum_dec  <= '0;
      r_temp_int <= '0;
      r_temp_dec <= '0;
      r_valid    <= 1'b0;
      r_timeout  <= 1'b0;
    end else begin
      r_valid   <= 1'b0;
      r_timeout <= w_timeout;
      if (r_state == S_CHECK && w_csum_ok) begin
        r_hum_int  <= r_shift[BYTE_HUM_INT*8 +: 8];
        r_hum_dec  <= r_shift[BYTE_HUM_DEC*8 +: 8];
        r_temp_int <= r_shift[BYTE_TEMP_INT*8 +: 8];
        r_temp_dec <= r_shift[BYTE_TEMP_DEC*8 +: 8];
        r_valid    <= 1'b1;
      end
    end
  end

`ifdef DHT11_CHECKSUM_EN
  logic r_cerr;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_cerr <= 1'b0;
    else     r_cerr <= (r_state == S_CHECK) && !w_csum_ok;
  end
  assign checksum_err = r_cerr;
`else
  assign checksum_err = 1'b0;
`endif

  assign hum_int  = r_hum_int;
  assign hum_dec  = r_hum_dec;
  assign temp_int = r_temp_int;
  assign temp_dec = r_temp_dec;
  assign valid    = r_valid;
  assign timeout  = r_timeout;
  assign busy     = (r_state != S_IDLE);

endmodule

// File: tb/tb_dht11_receiver.sv
// Drives DHT11 waveforms at 1 cycle per us and checks strobes/readings against a frame-level model.
module tb_dht11_receiver;

  localparam int K_VALID = 1;
  localparam int K_CERR  = 2;
  localparam int K_TOUT  = 3;

  typedef struct {
    int          kind;
    int          lo;
    int          hi;
    logic [31:0] data;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       dht11_data = 1'b1;
  logic [7:0] hum_int, hum_dec, temp_int, temp_dec;
  logic       valid, checksum_err, timeout, busy;

  int          cyc = 0;
  int          n_checks = 0;
  int          n_errs = 0;
  exp_t        q[$];
  logic [31:0] m_data = '0;

  dht11_receiver dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .dht11_data   (dht11_data),
    .hum_int      (hum_int),
    .hum_dec      (hum_dec),
    .temp_int     (temp_int),
    .temp_dec     (temp_dec),
    .valid        (valid),
    .checksum_err (checksum_err),
    .timeout      (timeout),
    .busy         (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // A bit reads as 1 when its high phase is at least 40 us long
  function automatic logic [39:0] decode(input logic [39:0] f, input int bidx, input int bw);
    logic [39:0] d;
    int w;
    d = '0;
    for (int i = 0; i < 40; i++) begin
      w = (i == bidx) ? bw : (f[39-i] ? 70 : 27);
      d[39-i] = (w >= 40);
    end
    return d;
  endfunction

  function automatic int kind_of(input logic [39:0] d);
`ifdef DHT11_CHECKSUM_EN
    logic [7:0] s;
    s = d[39:32] + d[31:24] + d[23:16] + d[15:8];
    return (s == d[7:0]) ? K_VALID : K_CERR;
`else
    return (d[0] === 1'bx) ? K_CERR : K_VALID;
`endif
  endfunction

  task automatic checker_loop();
    int seen;
    int ns;
    forever begin
      @(negedge clk);
      if (rst) begin
        m_data = '0;
        q.delete();
      end
      ns   = int'(valid) + int'(checksum_err) + int'(timeout);
      seen = valid ? K_VALID : (checksum_err ? K_CERR : (timeout ? K_TOUT : 0));
      chk("strobe_exclusive", 32'(ns > 1), 0);
      if (seen != 0) begin
        chk("busy_at_strobe", busy, 0);
        if (q.size() > 0 && cyc >= q[0].lo && cyc <= q[0].hi) begin
          chk("strobe_kind", seen, q[0].kind);
          if (q[0].kind == K_VALID) m_data = q[0].data;
          void'(q.pop_front());
        end else begin
          chk("unexpected_strobe", seen, 0);
        end
      end else if (q.size() > 0 && cyc > q[0].hi) begin
        chk("missed_strobe", 0, q[0].kind);
        void'(q.pop_front());
      end
      chk("outputs", {hum_int, hum_dec, temp_int, temp_dec}, m_data);
    end
  endtask

  // bidx/bw override one bit's high width; nbits<40 aborts the frame with the line low,
  // unless hold_high, which releases the line high and expects a timeout.
  task automatic send_frame(input logic [39:0] f, input int bidx, input int bw,
                            input int nbits, input int extra_start, input logic hold_high);
    logic [39:0] d;
    exp_t        e;
    int          w;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("busy_after_start", busy, 1);
    repeat (29) @(negedge clk);
    dht11_data = 1'b0; repeat (80) @(negedge clk);
    dht11_data = 1'b1; repeat (80) @(negedge clk);
    for (int i = 0; i < nbits; i++) begin
      dht11_data = 1'b0;
      if (i == extra_start) begin
        start = 1'b1; @(negedge clk); start = 1'b0;
        repeat (49) @(negedge clk);
      end else begin
        repeat (50) @(negedge clk);
      end
      w = (i == bidx) ? bw : (f[39-i] ? 70 : 27);
      dht11_data = 1'b1;
      repeat (w) @(negedge clk);
    end
    dht11_data = 1'b0;
    if (nbits == 40) begin
      d = decode(f, bidx, bw);
      e.kind = kind_of(d);
      e.lo   = cyc + 5;
      e.hi   = cyc + 5;
      e.data = d[39:8];
      q.push_back(e);
    end else if (!hold_high) begin
      return;
    end
    repeat (50) @(negedge clk);
    dht11_data = 1'b1;
    if (hold_high) begin
      e.kind = K_TOUT; e.lo = cyc + 200; e.hi = cyc + 210; e.data = '0;
      q.push_back(e);
      repeat (220) @(negedge clk);
    end else begin
      repeat (20) @(negedge clk);
    end
  endtask

  initial begin
    exp_t e;
    repeat (3) @(negedge clk);
    chk("rst_data", {hum_int, hum_dec, temp_int, temp_dec}, 0);
    chk("rst_strobes", {valid, checksum_err, timeout}, 0);
    chk("rst_busy", busy, 0);
    #2 rst = 1'b0;
    fork checker_loop(); join_none
    repeat (5) @(negedge clk);

    send_frame(40'h37_00_19_00_50, -1, 0, 40, -1, 1'b0);
    chk("a_hum_int", hum_int, 8'h37);
    chk("a_hum_dec", hum_dec, 8'h00);
    chk("a_temp_int", temp_int, 8'h19);
    chk("a_temp_dec", temp_dec, 8'h00);

    send_frame(40'h37_00_19_00_51, -1, 0, 40, -1, 1'b0);
    chk("b_hum_int", hum_int, 8'h37);

    // No response: line stays released after start
    start = 1'b1;
    e.kind = K_TOUT; e.lo = cyc + 200; e.hi = cyc + 210; e.data = '0;
    q.push_back(e);
    @(negedge clk);
    start = 1'b0;
    chk("noresp_busy", busy, 1);
    repeat (230) @(negedge clk);
    chk("noresp_busy_drop", busy, 0);
    chk("noresp_temp_int", temp_int, 8'h19);

    send_frame(40'h41_05_1C_03_65, -1, 0, 40, -1, 1'b0);
    chk("c_data", {hum_int, hum_dec, temp_int, temp_dec}, 32'h41_05_1C_03);

    send_frame(40'h00_00_00_00_00, 39, 39, 40, -1, 1'b0);
    send_frame(40'h00_00_00_00_00, 39, 40, 40, -1, 1'b0);
    send_frame(40'h00_00_00_00_01, 39, 40, 40, -1, 1'b0);
    send_frame(40'h00_00_00_00_01, 39, 39, 40, -1, 1'b0);
    send_frame(40'h00_00_00_01_01, 31, 39, 40, -1, 1'b0);
    send_frame(40'h00_00_00_01_01, 31, 40, 40, -1, 1'b0);
    chk("bnd_temp_dec_40us", temp_dec, 8'h01);

    send_frame(40'hFF_FF_FF_FF_FC, -1, 0, 20, -1, 1'b1);
    send_frame(40'h12_34_56_78_14, -1, 0, 40, -1, 1'b0);
    chk("d_data", {hum_int, hum_dec, temp_int, temp_dec}, 32'h12_34_56_78);

    send_frame(40'hAA_AA_AA_AA_A8, -1, 0, 10, -1, 1'b0);
    #2 rst = 1'b1;
    #1;
    chk("midrst_data", {hum_int, hum_dec, temp_int, temp_dec}, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_strobes", {valid, checksum_err, timeout}, 0);
    dht11_data = 1'b1;
    repeat (3) @(negedge clk);
    #2 rst = 1'b0;
    repeat (5) @(negedge clk);

    send_frame(40'h20_00_15_00_35, -1, 0, 40, 5, 1'b0);
    chk("e_data", {hum_int, hum_dec, temp_int, temp_dec}, 32'h20_00_15_00);

    repeat (20) @(negedge clk);
    chk("queue_drained", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

  initial begin
    #(95_000 * 10);
    $display("FAIL watchdog: simulation exceeded cycle budget at cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
